// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator host controllers.
package accel_pkg;

   localparam int RESULT_W = 16;
   localparam int Q_FRAC   = 8;

   localparam logic [RESULT_W-1:0] Q88_MOST_NEG = 16'h8000;

   typedef enum logic [2:0] {
      IDLE,
      GAP,
      START,
      WAIT,
      CAPTURE,
      FINISH,
      ABORT
   } state_t;

endpackage

// File: rtl/accel_watchdog.sv
// Cycle watchdog: clear restarts the count, expired is high on the
// TIMEOUT_CYCLES-th enabled cycle after a clear.
module accel_watchdog #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && count != LAST) begin
         count <= count + CW'(1);
      end
   end

   assign expired = enable && (count == LAST);

endmodule

// File: rtl/accel_run_ctrl.sv
// Host-side batch sequencer for the accelerator start/done interface.
// Optional start-to-done latency statistics: define ACC_LATENCY_STAT_EN.
module accel_run_ctrl #(
   parameter int RESULT_W       = accel_pkg::RESULT_W,
   parameter int CNT_W          = 8,
   parameter int START_GAP      = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run_req,
   input  logic [CNT_W-1:0]    run_count,
   output logic                acc_start,
   input  logic                acc_done,
   input  logic [RESULT_W-1:0] acc_result,
   output logic                res_valid,
   output logic [RESULT_W-1:0] res_data,
   output logic [CNT_W-1:0]    res_idx,
   input  logic                res_ready,
   output logic                busy,
   output logic                run_done,
   output logic                timeout_err,
   output logic [RESULT_W-1:0] best_data,
   output logic [CNT_W-1:0]    best_idx
`ifdef ACC_LATENCY_STAT_EN
   ,
   output logic [31:0]         lat_cycles,
   output logic [31:0]         lat_max
`endif
);

   import accel_pkg::*;

   localparam logic [RESULT_W-1:0] RES_MOST_NEG = (RESULT_W == accel_pkg::RESULT_W) ?
      RESULT_W'(Q88_MOST_NEG) : {1'b1, {(RESULT_W-1){1'b0}}};
   localparam int GW = $clog2(START_GAP + 2);

   state_t           state;
   logic             done_q;
   logic             rise;
   logic             accept;
   logic             gap_done;
   logic             wd_expired;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] idx;
   logic [GW-1:0]    gap_cnt;

   assign rise     = acc_done & ~done_q;
   assign accept   = run_req && (state == IDLE || state == FINISH || state == ABORT);
   assign gap_done = (int'(gap_cnt) + 1 >= START_GAP);

   accel_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == START),
      .enable  (state == WAIT),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         done_q      <= 1'b0;
         count       <= '0;
         idx         <= '0;
         gap_cnt     <= '0;
         acc_start   <= 1'b0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_idx     <= '0;
         busy        <= 1'b0;
         run_done    <= 1'b0;
         timeout_err <= 1'b0;
         best_data   <= '0;
         best_idx    <= '0;
      end else begin
         done_q    <= acc_done;
         // NOTE: pulse outputs default low here so each one lasts exactly one cycle.
         acc_start <= 1'b0;
         run_done  <= 1'b0;

         case (state)
            // FINISH/ABORT are the run_done cycle; busy is already low, so accept there too.
            IDLE, FINISH, ABORT: begin
               state <= IDLE;
               if (run_req) begin
                  timeout_err <= 1'b0;
                  if (run_count == '0) begin
                     state    <= FINISH;
                     run_done <= 1'b1;
                  end else begin
                     state     <= GAP;
                     count     <= run_count;
                     idx       <= '0;
                     gap_cnt   <= '0;
                     busy      <= 1'b1;
                     best_data <= RES_MOST_NEG;
                     best_idx  <= '0;
                  end
               end
            end

            GAP: begin
               // A done level left over from the previous inference must drop first.
               if (gap_done && !acc_done) begin
                  state     <= START;
                  acc_start <= 1'b1;
               end else if (int'(gap_cnt) < START_GAP) begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end

            START: state <= WAIT;

            WAIT: begin
               if (rise) begin
                  state     <= CAPTURE;
                  res_valid <= 1'b1;
                  res_data  <= acc_result;
                  res_idx   <= idx;
               end else if (wd_expired) begin
                  state       <= ABORT;
                  timeout_err <= 1'b1;
                  run_done    <= 1'b1;
                  busy        <= 1'b0;
                  res_valid   <= 1'b0;
               end
            end

            CAPTURE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if ($signed(res_data) > $signed(best_data)) begin
                     best_data <= res_data;
                     best_idx  <= res_idx;
                  end
                  if (idx + CNT_W'(1) == count) begin
                     state    <= FINISH;
                     run_done <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     state   <= GAP;
                     idx     <= idx + CNT_W'(1);
                     gap_cnt <= '0;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

`ifdef ACC_LATENCY_STAT_EN
   logic [31:0] lat_cnt;

   // lat_cnt equals cycles elapsed since the start pulse while in WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_cnt    <= '0;
         lat_cycles <= '0;
         lat_max    <= '0;
      end else begin
         if (state == START) begin
            lat_cnt <= 32'd1;
         end else if (state == WAIT) begin
            lat_cnt <= lat_cnt + 32'd1;
         end
         if (accept) begin
            lat_max <= '0;
         end else if (state == WAIT && rise) begin
            lat_cycles <= lat_cnt;
            if (lat_cnt > lat_max) begin
               lat_max <= lat_cnt;
            end
         end
      end
   end
`endif

endmodule
